clk_div_monitor: RTL
====================

# clk_div_monitor

Fast-domain monitor for the divided processor clock: samples the divided clock through a 2-flop synchronizer, emits single-cycle rise/fall strobes, and measures every half-period against an expected length. A small FSM declares lock after a run of correct half-periods and raises a sticky error when a locked clock drifts or stalls. It sits in the `clk` domain next to the divider and gates logic that must only run once the divided clock is known good.

## Interface
- HALF_PERIOD, 1: expected half-period of `div_clk` in `clk` cycles; legal range 1 to 2^CNT_W-2.
- LOCK_COUNT, 4: consecutive good half-periods required to assert `locked`; minimum 1.
- CNT_W, 8: width of the run counter and `half_cnt`.
- clk  input  1  fast clock; all flops on posedge.
- clr_n  input  1  reset; synchronous, active-low.
- div_clk  input  1  divided clock, sampled as data and treated as asynchronous.
- en  input  1  monitor enable; 0 forces IDLE.
- err_clr  input  1  one-cycle clear for the sticky `err`.
- rise  output  1  one-cycle strobe per synchronized rising edge.
- fall  output  1  one-cycle strobe per synchronized falling edge.
- phase  output  1  synchronized level of `div_clk` (s2).
- locked  output  1  high while FSM is in LOCKED.
- err  output  1  sticky: a locked clock lost lock.
- half_cnt  output  CNT_W  length of the last completed half-period.

## Operation
- Sync chain s1 <- div_clk, s2 <- s1, s3 <- s2; free-running regardless of `en`. rise = s2 & ~s3, fall = ~s2 & s3, edge = rise | fall.
- Run counter cnt: edge cycle -> 1; otherwise cnt+1, saturating at 2^CNT_W-1.
- Edge cycle: half_cnt <= cnt in ARM, TRACK and LOCKED; good iff cnt == HALF_PERIOD, early iff cnt < HALF_PERIOD.
- Late event: no edge in a cycle with cnt >= HALF_PERIOD (edge overdue).
- FSM states IDLE, ARM, TRACK, LOCKED; good_cnt counts 0..LOCK_COUNT.
- IDLE: en=1 -> ARM.
- ARM: first edge -> TRACK, good_cnt=0; edge not judged (partial half-period), late events ignored.
- TRACK: good edge -> good_cnt+1; reaching LOCK_COUNT -> LOCKED. Early edge -> good_cnt=0, stay. Late -> good_cnt=0, ARM.
- LOCKED: good edge -> stay. Early edge -> TRACK, good_cnt=0, set err. Late -> ARM, good_cnt=0, set err.
- en=0 in any state -> IDLE next cycle, good_cnt=0; `err` and `half_cnt` hold.
- err set and err_clr in same cycle: set wins. err_clr with no set: err=0 next cycle.
- Reset (clr_n=0 at posedge): s1..s3, cnt, good_cnt, half_cnt, err=0; state IDLE. Outputs after reset: rise=fall=phase=locked=err=0, half_cnt=0. Reset mid-lock drops `locked` on the next cycle with no `err`.
- After reset release with div_clk high, a spurious `rise` is produced; ARM absorbs it by design.

## Timing
- div_clk change before posedge k -> s1 at k, s2 at k+1; rise/fall high for the cycle between k+1 and k+2. Edge latency 2 cycles, strobe width exactly 1 cycle.
- Divide-by-2 source (toggles every clk): edge every cycle, cnt=1 at each edge.
- locked asserts the cycle after the edge that completes LOCK_COUNT good half-periods; deasserts the cycle after the offending early edge or late event, with err rising on that same cycle.
- half_cnt updates one cycle after the edge cycle.
- cnt saturation: stuck div_clk never wraps; half_cnt of the resuming edge reads 2^CNT_W-1.

## Test plan
- Reset: clr_n=0 for 3 cycles, div_clk toggling -> all outputs 0, state IDLE; en=0 after release -> locked stays 0, rise/fall still pulse.
- Lock on divide-by-2: HALF_PERIOD=1, LOCK_COUNT=4, en=1, div_clk toggling every cycle -> rise/fall alternate every cycle; locked=1 one cycle after the 5th detected edge (1 arm + 4 good), half_cnt=1, err=0.
- Stall: from LOCKED, hold div_clk at 1 -> one cycle after the first overdue cycle locked=0, err=1, state ARM; resume after 20 cycles -> half_cnt=21 on that edge (counter was 1 and incremented 20 times), relock after 4 more good edges, err stays 1.
- Wrong ratio: HALF_PERIOD=2 instance fed divide-by-2 source -> every edge early, never locks, err=0, half_cnt=1.
- Early edge and clear race: locked, inject one extra toggle (half-period 1 with HALF_PERIOD=2) while err_clr=1 that cycle -> err=1, state TRACK; err_clr one cycle later -> err=0.
- Saturation/reset mid-op: CNT_W=4, hold div_clk 30 cycles -> half_cnt=15 on resuming edge; clr_n=0 while locked -> locked=0 next cycle, err=0.

Source files
------------

// File: rtl/clk_div_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : clk_div_monitor
//  Description : Fast-domain monitor for a divided processor clock.
//                div_clk is brought into the clk domain through a two-flop
//                synchronizer and a third history flop. This gives one-cycle
//                rise/fall strobes and lets the monitor measure every
//                half-period against HALF_PERIOD. A four-state FSM declares
//                lock after LOCK_COUNT consecutive good half-periods. If a
//                locked clock later drifts (early edge) or stalls (overdue
//                edge), the FSM drops lock and raises a sticky error.
//
//  Parameters  : HALF_PERIOD - expected half-period in clk cycles
//                              (1 .. 2^CNT_W-2)
//                LOCK_COUNT  - good half-periods needed to lock (>= 1)
//                CNT_W       - width of the run counter and half_cnt
//
//  Ports       : clk      in   fast clock, all flops on posedge
//                clr_n    in   synchronous active-low reset
//                div_clk  in   divided clock, sampled as asynchronous data
//                en       in   monitor enable, 0 forces IDLE
//                err_clr  in   one-cycle clear for the sticky err
//                rise     out  one-cycle strobe per synchronized rising edge
//                fall     out  one-cycle strobe per synchronized falling edge
//                phase    out  synchronized level of div_clk
//                locked   out  high while the FSM is in LOCKED
//                err      out  sticky flag: a locked clock lost lock
//                half_cnt out  length of the last completed half-period
//
//  Revision    : 1.0 - initial release
// ============================================================================
module clk_div_monitor #(
    parameter int HALF_PERIOD = 1,
    parameter int LOCK_COUNT  = 4,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             div_clk,
    input  logic             en,
    input  logic             err_clr,
    output logic             rise,
    output logic             fall,
    output logic             phase,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] half_cnt
);

    // good_cnt must hold every value from 0 up to LOCK_COUNT.
    localparam int c_good_w = (LOCK_COUNT < 1) ? 1 : $clog2(LOCK_COUNT + 1);

    localparam logic [CNT_W-1:0]    c_cnt_max = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]    c_cnt_one = CNT_W'(1);
    localparam logic [CNT_W-1:0]    c_half    = CNT_W'(HALF_PERIOD);
    localparam logic [c_good_w-1:0] c_lock    = c_good_w'(LOCK_COUNT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARM    = 2'd1,
        ST_TRACK  = 2'd2,
        ST_LOCKED = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    logic                r_s1_q;
    logic                r_s2_q;
    logic                r_s3_q;
    logic [CNT_W-1:0]    r_cnt_q;
    logic [c_good_w-1:0] r_good_q;
    logic [CNT_W-1:0]    r_half_q;
    logic                r_err_q;
    logic                r_locked_q;
    state_t              r_state_q;

    // ------------------------------------------------------------------
    // Next-state values and decoded events
    // ------------------------------------------------------------------
    logic                w_rise;
    logic                w_fall;
    logic                w_edge;
    logic                w_good;
    logic                w_early;
    logic                w_late;
    logic                w_err_set;
    logic [c_good_w-1:0] w_good_inc;
    logic [CNT_W-1:0]    w_cnt_d;
    logic [c_good_w-1:0] w_good_d;
    logic [CNT_W-1:0]    w_half_d;
    logic                w_err_d;
    logic                w_locked_d;
    state_t              w_state_d;

    always_comb begin
        // s2 is the first metastability-safe sample; s3 is its history.
        w_rise = r_s2_q & ~r_s3_q;
        w_fall = ~r_s2_q & r_s3_q;
        w_edge = w_rise | w_fall;

        // The counter holds the number of cycles since the last edge, so
        // on an edge cycle it equals the length of the half-period that
        // just ended.
        w_good  = w_edge && (r_cnt_q == c_half);
        w_early = w_edge && (r_cnt_q < c_half);
        // With no edge and a full half-period already counted, the edge
        // is overdue. The clock has stalled or slowed down.
        w_late  = !w_edge && (r_cnt_q >= c_half);

        // Saturate so that a stuck div_clk never wraps around into a
        // value that looks like a legal half-period.
        if (w_edge) begin
            w_cnt_d = c_cnt_one;
        end else if (r_cnt_q == c_cnt_max) begin
            w_cnt_d = r_cnt_q;
        end else begin
            w_cnt_d = r_cnt_q + 1'b1;
        end

        w_good_inc = r_good_q + 1'b1;

        w_state_d = r_state_q;
        w_good_d  = r_good_q;
        w_half_d  = r_half_q;
        w_err_set = 1'b0;

        if (!en) begin
            // err and half_cnt intentionally hold across a disable.
            w_state_d = ST_IDLE;
            w_good_d  = '0;
        end else begin
            case (r_state_q)
                ST_IDLE: begin
                    w_state_d = ST_ARM;
                end

                ST_ARM: begin
                    // The first edge closes a half-period of unknown
                    // start, so it only marks the start of measuring.
                    // This also absorbs the spurious rise after reset.
                    if (w_edge) begin
                        w_half_d  = r_cnt_q;
                        w_state_d = ST_TRACK;
                        w_good_d  = '0;
                    end
                end

                ST_TRACK: begin
                    if (w_edge) begin
                        w_half_d = r_cnt_q;
                        if (w_good) begin
                            if (w_good_inc == c_lock) begin
                                w_state_d = ST_LOCKED;
                            end
                            w_good_d = w_good_inc;
                        end else if (w_early) begin
                            w_good_d = '0;
                        end else begin
                            // An over-long edge is normally caught first
                            // as a late event. Treat it the same way.
                            w_good_d  = '0;
                            w_state_d = ST_ARM;
                        end
                    end else if (w_late) begin
                        w_good_d  = '0;
                        w_state_d = ST_ARM;
                    end
                end

                ST_LOCKED: begin
                    if (w_edge) begin
                        w_half_d = r_cnt_q;
                        if (!w_good) begin
                            w_good_d  = '0;
                            w_err_set = 1'b1;
                            w_state_d = w_early ? ST_TRACK : ST_ARM;
                        end
                    end else if (w_late) begin
                        w_good_d  = '0;
                        w_err_set = 1'b1;
                        w_state_d = ST_ARM;
                    end
                end

                default: begin
                    w_state_d = ST_IDLE;
                    w_good_d  = '0;
                end
            endcase
        end

        // A new loss of lock wins over a clear in the same cycle, so the
        // event cannot be lost.
        if (w_err_set) begin
            w_err_d = 1'b1;
        end else if (err_clr) begin
            w_err_d = 1'b0;
        end else begin
            w_err_d = r_err_q;
        end

        w_locked_d = (w_state_d == ST_LOCKED);
    end

    // ------------------------------------------------------------------
    // Single sequential block: synchronizer, counters, FSM, outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            r_s1_q     <= 1'b0;
            r_s2_q     <= 1'b0;
            r_s3_q     <= 1'b0;
            r_cnt_q    <= '0;
            r_good_q   <= '0;
            r_half_q   <= '0;
            r_err_q    <= 1'b0;
            r_locked_q <= 1'b0;
            r_state_q  <= ST_IDLE;
        end else begin
            // The synchronizer runs freely so that phase and the strobes
            // stay valid while the monitor is disabled.
            r_s1_q     <= div_clk;
            r_s2_q     <= r_s1_q;
            r_s3_q     <= r_s2_q;
            r_cnt_q    <= w_cnt_d;
            r_good_q   <= w_good_d;
            r_half_q   <= w_half_d;
            r_err_q    <= w_err_d;
            r_locked_q <= w_locked_d;
            r_state_q  <= w_state_d;
        end
    end

    assign rise     = w_rise;
    assign fall     = w_fall;
    assign phase    = r_s2_q;
    assign locked   = r_locked_q;
    assign err      = r_err_q;
    assign half_cnt = r_half_q;

endmodule
`default_nettype wire
